// File: rtl/mmio_periph_hub.sv
// Memory-mapped board I/O hub: scanned 7-segment display, LED register,
// debounced switches and a free-running cycle timer behind a 32-byte window.
module mmio_periph_hub #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SW_WIDTH   = 24,
    parameter int unsigned LED_WIDTH  = 24,
    parameter int unsigned SCAN_DIV   = 20000,
    parameter int unsigned DEBOUNCE   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           addra,
    input  logic                  dram_we_wire,
    input  logic [31:0]           wdata,
    output logic                  sel,
    output logic [31:0]           rdata,
    input  logic [SW_WIDTH-1:0]   switch,
    output logic [LED_WIDTH-1:0]  lights,
    output logic [NUM_DIGITS-1:0] led_en,
    output logic [7:0]            seg
);

    localparam int unsigned DW  = NUM_DIGITS * 4;
    localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DBW = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        REG_DIG   = 3'd0,
        REG_LED   = 3'd1,
        REG_SW    = 3'd2,
        REG_CTRL  = 3'd3,
        REG_TIMER = 3'd4
    } reg_e;

    logic [DW-1:0]         dig;
    logic                  ctrl_en;
    logic [NUM_DIGITS-1:0] ctrl_mask;
    logic [31:0]           timer;
    logic [SW_WIDTH-1:0]   sync_a;
    logic [SW_WIDTH-1:0]   sync_b;
    logic [SW_WIDTH-1:0]   sw_val;
    logic [DBW-1:0]        db_cnt;
    logic [SCW-1:0]        scan_cnt;
    logic [IW-1:0]         idx;
    logic                  wr;
    logic [31:0]           rd_mux;
    logic [3:0]            nibble;
    logic                  lit;
    logic [7:0]            hex_seg;

    assign sel = (addra[31:5] == BASE_ADDR[31:5]);
    assign wr  = dram_we_wire && sel;

    always_comb begin
        rd_mux = '0;
        case (addra[4:2])
            REG_DIG:   rd_mux[DW-1:0] = dig;
            REG_LED:   rd_mux[LED_WIDTH-1:0] = lights;
            REG_SW:    rd_mux[SW_WIDTH-1:0] = sw_val;
            REG_CTRL: begin
                rd_mux[31]             = ctrl_en;
                rd_mux[NUM_DIGITS-1:0] = ctrl_mask;
            end
            REG_TIMER: rd_mux = timer;
            default:   rd_mux = '0;
        endcase
    end

    // Read captures pre-edge contents; a timer write overrides that edge's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            lights    <= '0;
            dig       <= '0;
            ctrl_en   <= 1'b1;
            ctrl_mask <= '1;
            timer     <= '0;
        end else begin
            rdata <= sel ? rd_mux : '0;
            timer <= timer + 32'd1;
            if (wr) begin
                case (addra[4:2])
                    REG_DIG:   dig <= wdata[DW-1:0];
                    REG_LED:   lights <= wdata[LED_WIDTH-1:0];
                    REG_CTRL: begin
                        ctrl_en   <= wdata[31];
                        ctrl_mask <= wdata[NUM_DIGITS-1:0];
                    end
                    REG_TIMER: timer <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Counter saturates at DEBOUNCE; any movement of the synchronised vector restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            db_cnt <= '0;
            sw_val <= '0;
        end else begin
            sync_a <= switch;
            sync_b <= sync_a;
            if (sync_a != sync_b) begin
                db_cnt <= '0;
            end else if (db_cnt != DBW'(DEBOUNCE)) begin
                db_cnt <= db_cnt + DBW'(1);
            end
            if (db_cnt == DBW'(DEBOUNCE)) begin
                sw_val <= sync_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SCW'(1);
        end
    end

    always_comb begin
        nibble = 4'(dig >> {idx, 2'b00});
        lit    = ctrl_en && ctrl_mask[idx];
        case (nibble)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hA7;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
        led_en = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
        seg    = lit ? hex_seg : 8'hFF;
    end

endmodule

// File: tb/tb_mmio_periph_hub.sv
// Directed and randomised bus/switch stimulus for mmio_periph_hub, checked
// against an arithmetic register, timer, scan and debounce model.
module tb_mmio_periph_hub;

    localparam int unsigned ND  = 8;
    localparam int unsigned SWW = 24;
    localparam int unsigned LW  = 24;
    localparam int unsigned SD  = 4;
    localparam int unsigned DB  = 16;
    localparam logic [31:0] BASE = 32'hFFFF_F000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   addra = '0;
    logic          dram_we_wire = 1'b0;
    logic [31:0]   wdata = '0;
    logic          sel;
    logic [31:0]   rdata;
    logic [SWW-1:0] switch = '0;
    logic [LW-1:0] lights;
    logic [ND-1:0] led_en;
    logic [7:0]    seg;

    mmio_periph_hub #(
        .NUM_DIGITS(ND),
        .SW_WIDTH(SWW),
        .LED_WIDTH(LW),
        .SCAN_DIV(SD),
        .DEBOUNCE(DB),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addra(addra),
        .dram_we_wire(dram_we_wire),
        .wdata(wdata),
        .sel(sel),
        .rdata(rdata),
        .switch(switch),
        .lights(lights),
        .led_en(led_en),
        .seg(seg)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned ecnt = 0;
    int unsigned kbase = 0;
    logic [31:0] tbase = '0;
    logic [31:0] m_dig, m_led, m_ctrl;
    logic [SWW-1:0] sw_model;
    logic [SWW-1:0] hist [64];
    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

    // Rising edges since reset release; edge 0 completes with ecnt = 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    // SW takes sample n-2 once samples n-2-DB .. n-2 all agree.
    always @(posedge clk or negedge rst_n) begin : sw_ref
        int unsigned n;
        bit stable;
        if (!rst_n) begin
            sw_model <= '0;
        end else begin
            n = ecnt;
            hist[n % 64] = switch;
            if (n >= DB + 2) begin
                stable = 1'b1;
                for (int unsigned j = 0; j <= DB; j++)
                    if (hist[(n - 2 - j) % 64] !== hist[(n - 2) % 64]) stable = 1'b0;
                if (stable) sw_model <= hist[(n - 2) % 64];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_dig  = '0;
        m_led  = '0;
        m_ctrl = 32'h8000_00FF;
        tbase  = '0;
        kbase  = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return m_dig;
            3'd1:    return m_led;
            3'd2:    return 32'(sw_model);
            3'd3:    return m_ctrl;
            3'd4:    return tbase + 32'(ecnt - kbase);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_disp(input string tag);
        int unsigned i;
        logic lt;
        logic [3:0] nib;
        logic [7:0] el, es;
        i   = (ecnt / SD) % ND;
        lt  = m_ctrl[31] && m_ctrl[i];
        nib = 4'(m_dig >> (4 * i));
        el  = lt ? ~(8'd1 << i) : 8'hFF;
        es  = lt ? hex_tab[nib] : 8'hFF;
        chk({tag, "_led_en"}, 32'(led_en), 32'(el));
        chk({tag, "_seg"}, 32'(seg), 32'(es));
    endtask

    // One bus cycle: drive at negedge, check the registered read after the next edge.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input string tag, output logic [31:0] rd);
        logic [31:0] exp;
        logic es;
        int unsigned k0;
        @(negedge clk);
        es  = (addr[31:5] == BASE[31:5]);
        exp = es ? model_read(addr[4:2]) : 32'h0;
        k0  = ecnt;
        addra = addr;
        wdata = data;
        dram_we_wire = we;
        #1 chk({tag, "_sel"}, 32'(sel), 32'(es));
        @(posedge clk);
        if (we && es) begin
            case (addr[4:2])
                3'd0: m_dig  = data;
                3'd1: m_led  = data & 32'h00FF_FFFF;
                3'd3: m_ctrl = data & 32'h8000_00FF;
                3'd4: begin tbase = data; kbase = k0 + 1; end
                default: ;
            endcase
        end
        #1 rd = rdata;
        dram_we_wire = 1'b0;
        chk(tag, rd, exp);
        chk_disp(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int unsigned r;
        logic [31:0] a;

        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_lights", 32'(lights), 32'h0);
        chk("rst_led_en", 32'(led_en), 32'hFE);
        chk("rst_seg", 32'(seg), 32'hC0);
        @(negedge clk) rst_n = 1'b1;

        bus(1'b0, BASE + 32'h0C, 32'h0, "ctrl_rst", rd);
        chk("ctrl_rst_val", rd, 32'h8000_00FF);
        bus(1'b0, BASE + 32'h10, 32'h0, "tmr_run", rd);

        bus(1'b1, BASE, 32'h1234_ABCF, "dig_wr", rd);
        repeat (40) bus(1'b0, BASE, 32'h0, "dig_scan", rd);
        chk("dig_val", rd, 32'h1234_ABCF);

        bus(1'b1, BASE + 32'h0C, 32'h8000_00F0, "ctrl_f0_wr", rd);
        repeat (36) bus(1'b0, BASE + 32'h0C, 32'h0, "ctrl_f0_scan", rd);
        chk("ctrl_f0_val", rd, 32'h8000_00F0);
        bus(1'b1, BASE + 32'h0C, 32'h0, "ctrl_off_wr", rd);
        repeat (10) bus(1'b0, BASE + 32'h0C, 32'h0, "ctrl_off_scan", rd);
        chk("blank_led_en", 32'(led_en), 32'hFF);
        chk("blank_seg", 32'(seg), 32'hFF);
        bus(1'b1, BASE + 32'h0C, 32'h8000_00FF, "ctrl_on_wr", rd);

        switch = 24'h00A5A5;
        repeat (25) bus(1'b0, BASE + 32'h08, 32'h0, "sw_settle", rd);
        chk("sw_steady", rd, 32'h0000_A5A5);
        switch = 24'h00A5A4;
        repeat (10) bus(1'b0, BASE + 32'h08, 32'h0, "sw_pulse", rd);
        switch = 24'h00A5A5;
        repeat (30) bus(1'b0, BASE + 32'h08, 32'h0, "sw_after", rd);
        chk("sw_glitch", rd, 32'h0000_A5A5);

        bus(1'b1, BASE + 32'h10, 32'hFFFF_FFFE, "tmr_wr", rd);
        bus(1'b0, BASE + 32'h10, 32'h0, "tmr_rd0", rd);
        chk("tmr_fffffffe", rd, 32'hFFFF_FFFE);
        bus(1'b0, BASE + 32'h10, 32'h0, "tmr_rd1", rd);
        chk("tmr_ffffffff", rd, 32'hFFFF_FFFF);
        bus(1'b0, BASE + 32'h10, 32'h0, "tmr_rd2", rd);
        chk("tmr_wrap", rd, 32'h0);

        bus(1'b1, BASE + 32'h04, 32'h0012_3456, "led_wr0", rd);
        bus(1'b1, BASE + 32'h04, 32'hFFAB_CDEF, "led_wr1", rd);
        chk("led_same_edge", rd, 32'h0012_3456);
        bus(1'b0, BASE + 32'h04, 32'h0, "led_rd", rd);
        chk("led_masked", rd, 32'h00AB_CDEF);
        chk("lights_pin", 32'(lights), 32'h00AB_CDEF);

        bus(1'b1, BASE + 32'h18, 32'hDEAD_BEEF, "hole_wr", rd);
        bus(1'b0, BASE + 32'h18, 32'h0, "hole_rd", rd);
        chk("hole_zero", rd, 32'h0);
        bus(1'b1, BASE + 32'h40, 32'h5555_5555, "out_wr", rd);
        bus(1'b0, BASE + 32'h40, 32'h0, "out_rd", rd);
        chk("out_zero", rd, 32'h0);
        bus(1'b0, BASE, 32'h0, "after_dig", rd);
        chk("dig_kept", rd, 32'h1234_ABCF);
        bus(1'b0, BASE + 32'h04, 32'h0, "after_led", rd);
        chk("led_kept", rd, 32'h00AB_CDEF);
        bus(1'b0, BASE + 32'h0C, 32'h0, "after_ctrl", rd);
        bus(1'b0, BASE + 32'h10, 32'h0, "after_tmr", rd);

        for (int unsigned t = 0; t < 400; t++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + 32'(r * 4);
            else if (r == 8) a = $urandom;
            else             a = BASE + 32'h20 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 15) == 0) switch = SWW'($urandom);
            bus(1'($urandom_range(0, 1)), a, $urandom, "rand", rd);
        end
        switch = SWW'($urandom);
        repeat (25) bus(1'b0, BASE + 32'h08, 32'h0, "rand_sw_settle", rd);

        @(negedge clk);
        #2 rst_n = 1'b0;
        reset_model();
        #1;
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_lights", 32'(lights), 32'h0);
        chk("midrst_led_en", 32'(led_en), 32'hFE);
        chk("midrst_seg", 32'(seg), 32'hC0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bus(1'b0, BASE + 32'h0C, 32'h0, "midrst_ctrl", rd);
        chk("midrst_ctrl_val", rd, 32'h8000_00FF);
        bus(1'b0, BASE, 32'h0, "midrst_dig", rd);
        chk("midrst_dig_val", rd, 32'h0);
        repeat (30) bus(1'b0, BASE + 32'h08, 32'h0, "midrst_sw", rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
